// File: rtl/qsel_pkg.sv
// Shared constants, FSM state encoding and the neighbour-entry record
// used by the next-hop selector.
package qsel_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int MEM_DEPTH  = 2048;

    typedef logic [WORD_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } qsel_state_t;

    typedef struct packed {
        word_t id;
        word_t cluster;
        word_t energy;
        word_t qvalue;
    } nbr_entry_t;

endpackage

// File: rtl/qsel_better.sv
// Candidate-vs-best decision: higher Q wins, energy breaks Q ties, full ties keep the incumbent.
// Optional energy floor enabled by QSEL_ENERGY_FILTER_EN.
module qsel_better
    import qsel_pkg::*;
(
    input  logic  found,
    input  word_t cand_q,
    input  word_t cand_energy,
    input  word_t best_q,
    input  word_t best_energy,
    input  word_t min_energy,
    output logic  better
);

    logic eligible;

`ifdef QSEL_ENERGY_FILTER_EN
    assign eligible = (cand_energy >= min_energy);
`else
    logic unused_min_energy;
    assign unused_min_energy = ^min_energy;
    assign eligible = 1'b1;
`endif

    // Strict comparisons so an exact duplicate never displaces the lower index.
    assign better = eligible &&
                    (!found ||
                     (cand_q > best_q) ||
                     ((cand_q == best_q) && (cand_energy > best_energy)));

endmodule

// File: rtl/qtable_nexthop_select.sv
// Scans neighbour Q-table banks one entry per clock and keeps the best next hop.
// Build option: QSEL_ENERGY_FILTER_EN (energy floor via minEnergy).
module qtable_nexthop_select
    import qsel_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic [15:0] neighborCount,
    input  logic [15:0] minEnergy,
    input  logic [15:0] mSourceID,
    input  logic [15:0] mClusterID,
    input  logic [15:0] mEnergyLeft,
    input  logic [15:0] mQValue,
    output logic [15:0] rd_index,
    output logic [15:0] nextHopID,
    output logic [15:0] nextHopClusterID,
    output logic [15:0] nextHopEnergy,
    output logic [15:0] nextHopQValue,
    output logic        found,
    output logic        busy,
    output logic        done
);

    qsel_state_t state;
    word_t       cnt;
    word_t       start_cnt;
    nbr_entry_t  best;
    nbr_entry_t  cand;
    logic        better;
    logic        cmp_valid;

    assign start_cnt = (neighborCount > 16'(MEM_DEPTH)) ? 16'(MEM_DEPTH) : neighborCount;

    assign cand = '{id: mSourceID, cluster: mClusterID,
                    energy: mEnergyLeft, qvalue: mQValue};

    // Bank data lags the address by one cycle, so the first SCAN cycle has nothing to compare.
    assign cmp_valid = ((state == SCAN) && (rd_index != '0)) || (state == DRAIN);

    qsel_better u_better (
        .found       (found),
        .cand_q      (cand.qvalue),
        .cand_energy (cand.energy),
        .best_q      (best.qvalue),
        .best_energy (best.energy),
        .min_energy  (minEnergy),
        .better      (better)
    );

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_index <= '0;
            best     <= '0;
            found    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        cnt      <= start_cnt;
                        best     <= '0;
                        found    <= 1'b0;
                        rd_index <= '0;
                        state    <= (start_cnt == '0) ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    if (cmp_valid && better) begin
                        best  <= cand;
                        found <= 1'b1;
                    end
                    if (rd_index == cnt - 16'd1) begin
                        state <= DRAIN;
                    end else begin
                        rd_index <= rd_index + 16'd1;
                    end
                end
                DRAIN: begin
                    if (better) begin
                        best  <= cand;
                        found <= 1'b1;
                    end
                    rd_index <= '0;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SCAN) || (state == DRAIN);
    assign done = (state == DONE);

    assign nextHopID        = best.id;
    assign nextHopClusterID = best.cluster;
    assign nextHopEnergy    = best.energy;
    assign nextHopQValue    = best.qvalue;

endmodule

// File: tb/tb_qtable_nexthop_select.sv
// Directed bench for qtable_nexthop_select with a registered-read bank model
// and a scoreboard of expected selections.
module tb_qtable_nexthop_select;
    import qsel_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] neighbor_count = '0;
    logic [15:0] min_energy = '0;
    logic [15:0] m_src, m_cl, m_e, m_q;
    logic [15:0] rd_index;
    logic [15:0] nh_id, nh_cl, nh_e, nh_q;
    logic        found, busy, done;

    logic [15:0] mem_id [16];
    logic [15:0] mem_cl [16];
    logic [15:0] mem_e  [16];
    logic [15:0] mem_q  [16];

    int tests = 0;
    int fails = 0;
    logic [64:0] exp_q [$];

    always #5 clk = ~clk;

    qtable_nexthop_select dut (
        .clk              (clk),
        .nrst             (nrst),
        .en               (en),
        .neighborCount    (neighbor_count),
        .minEnergy        (min_energy),
        .mSourceID        (m_src),
        .mClusterID       (m_cl),
        .mEnergyLeft      (m_e),
        .mQValue          (m_q),
        .rd_index         (rd_index),
        .nextHopID        (nh_id),
        .nextHopClusterID (nh_cl),
        .nextHopEnergy    (nh_e),
        .nextHopQValue    (nh_q),
        .found            (found),
        .busy             (busy),
        .done             (done)
    );

    // Bank model: data appears one cycle after the address
    always @(posedge clk) begin
        m_src <= mem_id[rd_index[3:0]];
        m_cl  <= mem_cl[rd_index[3:0]];
        m_e   <= mem_e[rd_index[3:0]];
        m_q   <= mem_q[rd_index[3:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input logic [15:0] id, input logic [15:0] cl,
                        input logic [15:0] e, input logic [15:0] q);
        mem_id[idx] = id;
        mem_cl[idx] = cl;
        mem_e[idx]  = e;
        mem_q[idx]  = q;
    endtask

    function automatic logic [64:0] model(input int n);
        int          eff;
        int          s;
        logic        f;
        logic        elig;
        logic [15:0] bid, bcl, be, bq;
        eff = (n > MEM_DEPTH) ? MEM_DEPTH : n;
        f = 1'b0; bid = '0; bcl = '0; be = '0; bq = '0;
        for (int i = 0; i < eff; i++) begin
            s = i % 16;
            elig = 1'b1;
`ifdef QSEL_ENERGY_FILTER_EN
            elig = (mem_e[s] >= min_energy);
`endif
            if (elig && (!f || mem_q[s] > bq || (mem_q[s] == bq && mem_e[s] > be))) begin
                f = 1'b1; bid = mem_id[s]; bcl = mem_cl[s]; be = mem_e[s]; bq = mem_q[s];
            end
        end
        return {f, bid, bcl, be, bq};
    endfunction

    task automatic run_scan(input string tag, input int n, input bit extra_en);
        int          eff;
        int          exp_lat;
        int          lat;
        bit          seen;
        logic [64:0] e;
        eff = (n > MEM_DEPTH) ? MEM_DEPTH : n;
        exp_lat = (eff == 0) ? 1 : eff + 2;
        neighbor_count = 16'(n);
        exp_q.push_back(model(n));
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        seen = 1'b0;
        lat = 0;
        while (!seen && lat < exp_lat + 5) begin
            @(negedge clk);
            lat++;
            en = 1'b0;
            if (extra_en && lat == 2) begin
                en = 1'b1;
                neighbor_count = 16'd9;
            end
            if (lat == 1 && eff > 0) check({tag, " busy"}, 32'(busy), 32'd1);
            if (lat <= eff && eff <= 16) check({tag, " rd_index"}, 32'(rd_index), 32'(lat - 1));
            if (done) seen = 1'b1;
        end
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " done latency"}, 32'(lat), 32'(exp_lat));
        e = exp_q.pop_front();
        check({tag, " found"}, 32'(found), 32'(e[64]));
        check({tag, " id"}, 32'(nh_id), 32'(e[63:48]));
        check({tag, " cluster"}, 32'(nh_cl), 32'(e[47:32]));
        check({tag, " energy"}, 32'(nh_e), 32'(e[31:16]));
        check({tag, " qvalue"}, 32'(nh_q), 32'(e[15:0]));
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        check({tag, " rd_index at done"}, 32'(rd_index), 32'd0);
        @(negedge clk);
        check({tag, " done pulse width"}, 32'(done), 32'd0);
        check({tag, " idle after done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int done_count;
        for (int i = 0; i < 16; i++) load(i, 16'd0, 16'd0, 16'd0, 16'd0);
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset found", 32'(found), 32'd0);
        check("reset rd_index", 32'(rd_index), 32'd0);
        nrst = 1'b0;
        repeat (2) @(negedge clk);

        load(0, 16'd1, 16'd2, 16'h8000, 16'h3000);
        run_scan("single", 1, 1'b0);
        check("single direct id", 32'(nh_id), 32'd1);
        check("single direct q", 32'(nh_q), 32'h3000);

        load(0, 16'd1, 16'd7, 16'h1000, 16'h3000);
        load(1, 16'd2, 16'd7, 16'h1000, 16'hB800);
        load(2, 16'd3, 16'd7, 16'h1000, 16'h1000);
        run_scan("max", 3, 1'b0);
        check("max direct id", 32'(nh_id), 32'd2);
        check("max direct q", 32'(nh_q), 32'hB800);

        load(0, 16'd4, 16'd1, 16'h1800, 16'h3000);
        load(1, 16'd5, 16'd1, 16'h8000, 16'h3000);
        run_scan("tie energy", 2, 1'b0);
        check("tie energy direct id", 32'(nh_id), 32'd5);

        load(0, 16'd8, 16'd3, 16'h5000, 16'h4000);
        load(1, 16'd9, 16'd3, 16'h5000, 16'h4000);
        run_scan("tie full", 2, 1'b0);
        check("tie full direct id", 32'(nh_id), 32'd8);

        run_scan("empty", 0, 1'b0);
        check("empty direct found", 32'(found), 32'd0);

        for (int i = 0; i < 16; i++)
            load(i, 16'(100 + i), 16'($urandom_range(0, 15)),
                 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        run_scan("busy en", 5, 1'b1);
        run_scan("random", 16, 1'b0);

        load(3, 16'd77, 16'd1, 16'h0001, 16'hFFFF);
        run_scan("clamp", 3000, 1'b0);
        check("clamp direct id", 32'(nh_id), 32'd77);

        load(0, 16'd5, 16'd1, 16'h1800, 16'hB800);
        load(1, 16'd6, 16'd1, 16'h8000, 16'h3000);
        min_energy = 16'h4000;
        run_scan("filter", 2, 1'b0);
`ifdef QSEL_ENERGY_FILTER_EN
        check("filter direct id", 32'(nh_id), 32'd6);
`else
        check("filter direct id", 32'(nh_id), 32'd5);
`endif
        min_energy = 16'hF000;
        run_scan("filter all", 2, 1'b0);
        min_energy = 16'h0000;

        // Abort a scan with reset three cycles after the start edge
        neighbor_count = 16'd4;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort found", 32'(found), 32'd0);
        check("abort rd_index", 32'(rd_index), 32'd0);
        check("abort id", 32'(nh_id), 32'd0);
        check("abort q", 32'(nh_q), 32'd0);
        check("abort energy", 32'(nh_e), 32'd0);
        check("abort cluster", 32'(nh_cl), 32'd0);
        @(negedge clk);
        nrst = 1'b0;
        done_count = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_count++;
        end
        check("abort no done", 32'(done_count), 32'd0);
        check("abort idle", 32'(busy), 32'd0);

        run_scan("after abort", 16, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
